// File: rtl/bcd_game_timer.sv
// bcd_game_timer: multi-digit BCD seconds timer with load, start/pause, up/down count and expiry.
// Define BCD_GAME_TIMER_LAP_EN to add the lap input and lap_count capture register.
module bcd_game_timer #(
  parameter int CLOCK_FREQ = 10_000,
  parameter int TICK_HZ    = 1,
  parameter int DIGITS     = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_val,
  input  logic                start,
  input  logic                pause,
  input  logic                count_down,
`ifdef BCD_GAME_TIMER_LAP_EN
  input  logic                lap,
  output logic [4*DIGITS-1:0] lap_count,
`endif
  output logic [4*DIGITS-1:0] count,
  output logic                tick,
  output logic                running,
  output logic                done,
  output logic                expired,
  output logic [1:0]          fsm_state
);

  localparam int DIV = CLOCK_FREQ / TICK_HZ;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int CW  = 4 * DIGITS;
  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Handshake: none; load/start are single-cycle pulses sampled on posedge clk,
  // tick/done are single-cycle registered pulses aligned with the new count.
  logic [1:0]    state;
  logic [PW-1:0] presc;
  logic          dir_down;
  logic [CW-1:0] load_sat;
  logic [CW-1:0] count_inc;
  logic [CW-1:0] count_dec;
  logic          count_zero;
  logic          inc_wraps;
  logic          dec_hits_zero;

  always_comb begin : saturate_load
    load_sat = '0;
    for (int i = 0; i < DIGITS; i++) begin
      load_sat[4*i +: 4] = (load_val[4*i +: 4] > 4'd9) ? 4'd9 : load_val[4*i +: 4];
    end
  end

  always_comb begin : bcd_step
    logic carry;
    logic borrow;
    count_inc = '0;
    count_dec = '0;
    carry     = 1'b1;
    borrow    = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (count[4*i +: 4] == 4'd9) begin
          count_inc[4*i +: 4] = 4'd0;
        end else begin
          count_inc[4*i +: 4] = count[4*i +: 4] + 4'd1;
          carry = 1'b0;
        end
      end else begin
        count_inc[4*i +: 4] = count[4*i +: 4];
      end
      if (borrow) begin
        if (count[4*i +: 4] == 4'd0) begin
          count_dec[4*i +: 4] = 4'd9;
        end else begin
          count_dec[4*i +: 4] = count[4*i +: 4] - 4'd1;
          borrow = 1'b0;
        end
      end else begin
        count_dec[4*i +: 4] = count[4*i +: 4];
      end
    end
  end

  // Only all-9s increments to zero, and only a count of 1 decrements to zero.
  assign count_zero    = (count == '0);
  assign inc_wraps     = (count_inc == '0);
  assign dec_hits_zero = (count_dec == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      presc    <= '0;
      dir_down <= 1'b0;
      count    <= '0;
      tick     <= 1'b0;
      done     <= 1'b0;
    end else begin
      tick <= 1'b0;
      done <= 1'b0;
      if (load) begin
        count <= load_sat;
        presc <= '0;
        state <= S_IDLE;
      end else begin
        case (state)
          S_RUN: begin
            if (!pause) begin
              if (presc == PRESC_LAST) begin
                presc <= '0;
                tick  <= 1'b1;
                if (dir_down) begin
                  count <= count_dec;
                  if (dec_hits_zero) begin
                    done  <= 1'b1;
                    state <= S_DONE;
                  end
                end else begin
                  count <= count_inc;
                  if (inc_wraps) done <= 1'b1;
                end
              end else begin
                presc <= presc + PW'(1);
              end
            end
          end
          default: begin
            // IDLE, DONE (and any illegal encoding) accept start.
            if (start) begin
              dir_down <= count_down;
              presc    <= '0;
              if (count_down && count_zero) begin
                state <= S_DONE;
                done  <= 1'b1;
              end else begin
                state <= S_RUN;
              end
            end
          end
        endcase
      end
    end
  end

`ifdef BCD_GAME_TIMER_LAP_EN
  // Captures the value held before any step on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      lap_count <= '0;
    end else if (lap && (state == S_RUN)) begin
      lap_count <= count;
    end
  end
`endif

  assign running   = (state == S_RUN);
  assign expired   = (state == S_DONE);
  assign fsm_state = state;

endmodule

// File: tb/tb_bcd_game_timer.sv
// Testbench for bcd_game_timer: directed test-plan scenarios plus random traffic against an integer model.
`timescale 1ns/1ps
module tb_bcd_game_timer;

  localparam int CLOCK_FREQ = 10;
  localparam int TICK_HZ    = 1;
  localparam int DIGITS     = 2;
  localparam int DIV        = CLOCK_FREQ / TICK_HZ;
  localparam int CW         = 4 * DIGITS;
  localparam int MAXV       = 10 ** DIGITS - 1;
  localparam int W          = 32 + CW + 2;

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_DONE = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          load = 1'b0;
  logic [CW-1:0] load_val = '0;
  logic          start = 1'b0;
  logic          pause = 1'b0;
  logic          count_down = 1'b0;
  logic [CW-1:0] count;
  logic          tick;
  logic          running;
  logic          done;
  logic          expired;
  logic [1:0]    fsm_state;
`ifdef BCD_GAME_TIMER_LAP_EN
  logic          lap = 1'b0;
  logic [CW-1:0] lap_count;
`endif

  bcd_game_timer #(
    .CLOCK_FREQ(CLOCK_FREQ),
    .TICK_HZ   (TICK_HZ),
    .DIGITS    (DIGITS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .load_val  (load_val),
    .start     (start),
    .pause     (pause),
    .count_down(count_down),
`ifdef BCD_GAME_TIMER_LAP_EN
    .lap       (lap),
    .lap_count (lap_count),
`endif
    .count     (count),
    .tick      (tick),
    .running   (running),
    .done      (done),
    .expired   (expired),
    .fsm_state (fsm_state)
  );

  // ---------------- clock ----------------
  initial forever #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [W-1:0] exp_q[$];

  int m_val   = 0;
  int m_state = M_IDLE;
  int m_phase = 0;
  bit m_dir   = 1'b0;
  int m_lap   = 0;

  function automatic int bcd_to_int_sat(logic [CW-1:0] v);
    int r;
    int d;
    r = 0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      d = int'(v[4*i +: 4]);
      if (d > 9) d = 9;
      r = r * 10 + d;
    end
    return r;
  endfunction

  function automatic logic [CW-1:0] int_to_bcd(int n);
    logic [CW-1:0] r;
    r = '0;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(n % 10);
      n = n / 10;
    end
    return r;
  endfunction

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cyc %0d", name, act, act, exp, exp, cyc);
    end
  endtask

  task automatic push_event(int at, int val, bit t, bit d);
    exp_q.push_back({at[31:0], int_to_bcd(val), t, d});
  endtask

  // Reference model: integer count, elapsed-cycle phase, evaluated on each rising edge.
  task automatic model_thread();
    forever begin
      @(posedge clk);
      cyc++;
      if (rst) begin
        m_val   = 0;
        m_state = M_IDLE;
        m_phase = 0;
        m_lap   = 0;
      end else begin
`ifdef BCD_GAME_TIMER_LAP_EN
        if (lap && m_state == M_RUN) m_lap = m_val;
`endif
        if (load) begin
          m_val   = bcd_to_int_sat(load_val);
          m_state = M_IDLE;
          m_phase = 0;
        end else if (m_state != M_RUN) begin
          if (start) begin
            m_dir   = count_down;
            m_phase = 0;
            if (count_down && m_val == 0) begin
              m_state = M_DONE;
              push_event(cyc, 0, 1'b0, 1'b1);
            end else begin
              m_state = M_RUN;
            end
          end
        end else if (!pause) begin
          m_phase++;
          if (m_phase == DIV) begin
            m_phase = 0;
            if (m_dir) begin
              m_val = m_val - 1;
              if (m_val == 0) begin
                m_state = M_DONE;
                push_event(cyc, m_val, 1'b1, 1'b1);
              end else begin
                push_event(cyc, m_val, 1'b1, 1'b0);
              end
            end else if (m_val == MAXV) begin
              m_val = 0;
              push_event(cyc, m_val, 1'b1, 1'b1);
            end else begin
              m_val = m_val + 1;
              push_event(cyc, m_val, 1'b1, 1'b0);
            end
          end
        end
      end
    end
  endtask

  // Monitor: pops an expected event whenever the DUT pulses tick or done.
  task automatic monitor_thread();
    logic [W-1:0] e;
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0 && int'(exp_q[0][W-1 -: 32]) < cyc) begin
        e = exp_q.pop_front();
        checks++;
        errors++;
        $display("FAIL missing_event: no tick/done seen, expected at cyc %0d count 0x%0h (now cyc %0d)",
                 e[W-1 -: 32], e[CW+1 -: CW], cyc);
      end
      if (tick || done) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_event: tick=%0b done=%0b count=0x%0h at cyc %0d, expected none",
                   tick, done, count, cyc);
        end else begin
          e = exp_q.pop_front();
          chk("event_cyc", cyc, int'(e[W-1 -: 32]));
          chk("event_count", int'(count), int'(e[CW+1 -: CW]));
          chk("event_tick", int'(tick), int'(e[1]));
          chk("event_done", int'(done), int'(e[0]));
        end
      end
      chk("count_level", int'(count), int'(int_to_bcd(m_val)));
      chk("running_level", int'(running), (m_state == M_RUN) ? 1 : 0);
      chk("expired_level", int'(expired), (m_state == M_DONE) ? 1 : 0);
      checks++;
      if (fsm_state == 2'b11) begin
        errors++;
        $display("FAIL fsm_state_legal: got %0d expected 0..2 at cyc %0d", fsm_state, cyc);
      end
`ifdef BCD_GAME_TIMER_LAP_EN
      chk("lap_level", int'(lap_count), int'(int_to_bcd(m_lap)));
`endif
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycles(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_load(logic [CW-1:0] v);
    @(negedge clk);
    load     = 1'b1;
    load_val = v;
    @(negedge clk);
    load     = 1'b0;
  endtask

  task automatic do_start(logic dn);
    @(negedge clk);
    start      = 1'b1;
    count_down = dn;
    @(negedge clk);
    start      = 1'b0;
  endtask

  task automatic wait_tick(string name, output int at);
    at = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (tick) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) begin
      checks++;
      errors++;
      $display("FAIL %s: no tick within 200 cycles, expected one", name);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int c0;
    int t1;
    int t2;
    int t3;
    int op;

    fork
      model_thread();
      monitor_thread();
    join_none

    // Reset
    cycles(3);
    rst = 1'b0;
    cycles(50);
    chk("reset_count", int'(count), 0);
    chk("reset_flags", int'({tick, done, running, expired}), 0);

    // Down count 03 -> 00
    do_load(8'h03);
    do_start(1'b1);
    c0 = cyc;
    wait_tick("down_step1", t1);
    chk("down_first_gap", t1 - c0, 10);
    chk("down_step1_count", int'(count), 'h02);
    wait_tick("down_step2", t2);
    chk("down_gap2", t2 - t1, 10);
    chk("down_step2_count", int'(count), 'h01);
    wait_tick("down_step3", t3);
    chk("down_gap3", t3 - t2, 10);
    chk("down_zero_count", int'(count), 'h00);
    chk("down_zero_done", int'(done), 1);
    @(negedge clk);
    chk("down_expired", int'(expired), 1);
    chk("down_hold_count", int'(count), 'h00);
    chk("down_no_tick", int'(tick), 0);

    // Up wrap 98 -> 99 -> 00 -> 01
    do_load(8'h98);
    do_start(1'b0);
    wait_tick("up_step1", t1);
    chk("up_99", int'(count), 'h99);
    chk("up_run1", int'(running), 1);
    wait_tick("up_step2", t2);
    chk("up_wrap_00", int'(count), 'h00);
    chk("up_wrap_done", int'(done), 1);
    chk("up_run2", int'(running), 1);
    wait_tick("up_step3", t3);
    chk("up_01", int'(count), 'h01);
    chk("up_01_done", int'(done), 0);
    chk("up_run3", int'(running), 1);

    // Invalid load saturates, then pause stretches a period
    do_load(8'h1F);
    chk("sat_load", int'(count), 'h19);
    chk("load_idle", int'(running), 0);
    do_start(1'b1);
    wait_tick("pause_step1", t1);
    chk("pause_step1_count", int'(count), 'h18);
    cycles(3);
    pause = 1'b1;
    cycles(7);
    pause = 1'b0;
    wait_tick("pause_step2", t2);
    chk("pause_gap", t2 - t1, 17);
    chk("pause_step2_count", int'(count), 'h17);

    // Zero start in down mode
    do_load(8'h00);
    do_start(1'b1);
    chk("zero_start_done", int'(done), 1);
    chk("zero_start_tick", int'(tick), 0);
    chk("zero_start_expired", int'(expired), 1);

    // Load on a step cycle aborts the step
    do_load(8'h30);
    do_start(1'b1);
    cycles(8);
    do_load(8'h05);
    chk("abort_count", int'(count), 'h05);
    chk("abort_tick", int'(tick), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_idle", int'(running), 0);
    cycles(15);

`ifdef BCD_GAME_TIMER_LAP_EN
    // Lap on a step cycle captures the pre-step value
    do_load(8'h41);
    do_start(1'b0);
    cycles(8);
    @(negedge clk);
    lap = 1'b1;
    @(negedge clk);
    lap = 1'b0;
    chk("lap_capture", int'(lap_count), 'h41);
    chk("lap_step_count", int'(count), 'h42);
`endif

    // Random traffic
    for (int n = 0; n < 150; n++) begin
      op = int'($urandom_range(0, 9));
      case (op)
        0: do_load(CW'($urandom));
        1, 2: do_start(1'($urandom_range(0, 1)));
        3: begin
          @(negedge clk);
          pause = 1'b1;
          cycles(int'($urandom_range(1, 15)));
          pause = 1'b0;
        end
        4: begin
          if ($urandom_range(0, 3) == 0) begin
            @(negedge clk);
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
          end else begin
            cycles(int'($urandom_range(1, 5)));
          end
        end
        5: begin
`ifdef BCD_GAME_TIMER_LAP_EN
          @(negedge clk);
          lap = 1'b1;
          @(negedge clk);
          lap = 1'b0;
`else
          cycles(2);
`endif
        end
        6: begin
          @(negedge clk);
          load       = 1'b1;
          load_val   = CW'($urandom);
          start      = 1'b1;
          count_down = 1'($urandom_range(0, 1));
          @(negedge clk);
          load  = 1'b0;
          start = 1'b0;
        end
        default: cycles(int'($urandom_range(1, 25)));
      endcase
    end

    cycles(5);
    chk("exp_q_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
